// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, handshake/prefix state types and a byte classifier.
// Combinational definitions only; no latency or flow control of its own.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT  = 8'hE0;
   localparam logic [7:0] PS2_BRK  = 8'hF0;
   localparam logic [7:0] PS2_ERR0 = 8'h00;
   localparam logic [7:0] PS2_ERR1 = 8'hFF;

   typedef enum logic {
      IDLE,
      ACK
   } hs_state_t;

   typedef enum logic [1:0] {
      NORM,
      E0,
      F0,
      E0F0
   } pfx_state_t;

   // Overrun/error markers from the receiver; they abort any prefix sequence.
   function automatic logic is_err_code(input logic [7:0] b);
      return (b == PS2_ERR0) || (b == PS2_ERR1);
   endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Receiver FIFO head: byte + non-empty flag towards the tracker, active-low pop strobe back.
// The pop strobe is low for one cycle per consumed byte; the FIFO retires its head on it.
interface ps2_key_tracker_if;
   logic [7:0] ps2_byte;
   logic       ps2_ready;
   logic       nextdata_n;

   modport master (
      output ps2_byte,
      output ps2_ready,
      input  nextdata_n
   );

   modport slave (
      input  ps2_byte,
      input  ps2_ready,
      output nextdata_n
   );
endinterface

// File: rtl/bcd_cnt2.sv
// Two-digit BCD counter, increments one cycle after inc, wraps 99 -> 00.
// No backpressure: every inc pulse is counted.
module bcd_cnt2 (
   input  logic       clk,
   input  logic       rest,
   input  logic       inc,
   output logic [7:0] q
);

   logic [7:0] r_q;

   always_ff @(posedge clk) begin
      if (rest) begin
         r_q <= 8'h00;
      end else if (inc) begin
         if (r_q == 8'h99) begin
            r_q <= 8'h00;
         end else if (r_q[3:0] == 4'd9) begin
            r_q <= {r_q[7:4] + 4'd1, 4'd0};
         end else begin
            r_q <= {r_q[7:4], r_q[3:0] + 4'd1};
         end
      end
   end

   assign q = r_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Pops PS/2 scan codes, strips E0/F0 prefixes, tracks the held key and counts presses in BCD.
// Outputs update one cycle after the byte is latched; at most one pop every two cycles.
module ps2_key_tracker
   import ps2_pkg::*;
(
   input  logic                     clk,
   input  logic                     rest,
   ps2_key_tracker_if.slave         rx,
   output logic [7:0]               key_code,
   output logic                     key_ext,
   output logic                     pressed,
   output logic                     key_event,
   output logic [7:0]               press_cnt
);

   hs_state_t  r_hs;
   pfx_state_t r_pfx;
   logic [7:0] r_byte;
   logic [7:0] r_key_code;
   logic       r_key_ext;
   logic       r_pressed;
   logic       r_key_event;

   logic       w_ack;
   logic       w_ext;
   logic       w_brk;
   logic       w_is_code;
   logic       w_match;
   logic       w_new_press;
   logic       w_release;

   assign w_ack       = (r_hs == ACK);
   assign w_ext       = (r_pfx == E0) || (r_pfx == E0F0);
   assign w_brk       = (r_pfx == F0) || (r_pfx == E0F0);
   assign w_is_code   = (r_byte != PS2_EXT) && (r_byte != PS2_BRK) && !is_err_code(r_byte);
   assign w_match     = (r_byte == r_key_code) && (w_ext == r_key_ext);
   // A make of the already-held key is typematic repeat, not a new press.
   assign w_new_press = w_ack && w_is_code && !w_brk && !(w_match && r_pressed);
   assign w_release   = w_ack && w_is_code && w_brk && w_match;

   always_ff @(posedge clk) begin
      if (rest) begin
         r_hs        <= IDLE;
         r_pfx       <= NORM;
         r_byte      <= 8'h00;
         r_key_code  <= 8'h00;
         r_key_ext   <= 1'b0;
         r_pressed   <= 1'b0;
         r_key_event <= 1'b0;
      end else begin
         r_key_event <= w_new_press;
         if (w_new_press) begin
            r_key_code <= r_byte;
            r_key_ext  <= w_ext;
            r_pressed  <= 1'b1;
         end else if (w_release) begin
            r_pressed  <= 1'b0;
         end

         case (r_hs)
            IDLE: begin
               if (rx.ps2_ready) begin
                  r_byte <= rx.ps2_byte;
                  r_hs   <= ACK;
               end
            end
            ACK: begin
               r_hs <= IDLE;
               if (r_byte == PS2_EXT) begin
                  r_pfx <= E0;
               end else if (r_byte == PS2_BRK) begin
                  if (r_pfx == NORM) begin
                     r_pfx <= F0;
                  end else if (r_pfx == E0) begin
                     r_pfx <= E0F0;
                  end
               end else begin
                  r_pfx <= NORM;
               end
            end
            default: r_hs <= IDLE;
         endcase
      end
   end

   assign rx.nextdata_n = !w_ack;
   assign key_code      = r_key_code;
   assign key_ext       = r_key_ext;
   assign pressed       = r_pressed;
   assign key_event     = r_key_event;

   bcd_cnt2 u_press_cnt (
      .clk  (clk),
      .rest (rest),
      .inc  (w_new_press),
      .q    (press_cnt)
   );

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed and randomized scan-code sequences against a behavioural key-state model.
module tb_ps2_key_tracker;

   logic       clk = 1'b0;
   logic       rest;
   logic [7:0] key_code;
   logic       key_ext;
   logic       pressed;
   logic       key_event;
   logic [7:0] press_cnt;

   always #5 clk = ~clk;

   ps2_key_tracker_if rx_if ();

   ps2_key_tracker dut (
      .clk       (clk),
      .rest      (rest),
      .rx        (rx_if),
      .key_code  (key_code),
      .key_ext   (key_ext),
      .pressed   (pressed),
      .key_event (key_event),
      .press_cnt (press_cnt)
   );

   int tests = 0;
   int fails = 0;

   // Receiver FIFO model: pops on a low strobe, drives the head mid-cycle.
   logic [7:0] fifo[$];
   int         ack_cnt = 0;
   int         ack_b2b = 0;
   int         ev_seen = 0;
   logic       prev_nd = 1'b1;

   always @(negedge clk) begin
      if (rx_if.nextdata_n === 1'b0) begin
         ack_cnt++;
         if (prev_nd === 1'b0) ack_b2b++;
         if (fifo.size() > 0) void'(fifo.pop_front());
      end
      prev_nd = rx_if.nextdata_n;
      rx_if.ps2_ready = (fifo.size() > 0);
      rx_if.ps2_byte  = (fifo.size() > 0) ? fifo[0] : 8'($urandom);
   end

   always @(posedge clk) begin
      if (key_event === 1'b1) ev_seen++;
   end

   // Reference model of key state.
   int m_key, m_ext, m_pressed, m_cnt, m_events;
   bit pend_ext, pend_brk, last_new;

   task automatic model_reset();
      m_key = 0; m_ext = 0; m_pressed = 0; m_cnt = 0;
      pend_ext = 0; pend_brk = 0;
   endtask

   task automatic model_byte(input int b);
      last_new = 0;
      if (b == 'hE0) begin
         pend_ext = 1; pend_brk = 0;
      end else if (b == 'hF0) begin
         pend_brk = 1;
      end else if (b == 'h00 || b == 'hFF) begin
         pend_ext = 0; pend_brk = 0;
      end else begin
         if (!pend_brk) begin
            if (!(b == m_key && int'(pend_ext) == m_ext && m_pressed == 1)) begin
               m_key = b; m_ext = int'(pend_ext); m_pressed = 1;
               m_cnt = (m_cnt + 1) % 100;
               m_events++;
               last_new = 1;
            end
         end else if (b == m_key && int'(pend_ext) == m_ext) begin
            m_pressed = 0;
         end
         pend_ext = 0; pend_brk = 0;
      end
   endtask

   function automatic logic [7:0] bcd(input int n);
      return 8'((n / 10) * 16 + (n % 10));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".key_code"},  32'(key_code),  32'(m_key));
      chk({tag, ".key_ext"},   32'(key_ext),   32'(m_ext));
      chk({tag, ".pressed"},   32'(pressed),   32'(m_pressed));
      chk({tag, ".press_cnt"}, 32'(press_cnt), 32'(bcd(m_cnt)));
   endtask

   // One byte, pipeline idle: checks pop latency and the event pulse exactly.
   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      fifo.push_back(b);
      model_byte(int'(b));
      @(negedge clk);
      @(negedge clk);
      chk("pop_latency", 32'(rx_if.nextdata_n), 32'(0));
      @(negedge clk);
      chk("key_event", 32'(key_event), 32'(last_new));
      check_all("send");
   endtask

   task automatic burst(input logic [7:0] bytes[$]);
      bit done = 0;
      @(posedge clk); #1;
      foreach (bytes[i]) begin
         fifo.push_back(bytes[i]);
         model_byte(int'(bytes[i]));
      end
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (fifo.size() == 0 && rx_if.nextdata_n === 1'b1) done = 1;
      end
      chk("burst_drained", 32'(done), 32'(1));
      repeat (3) @(negedge clk);
      check_all("burst");
      chk("burst.events", 32'(ev_seen), 32'(m_events));
   endtask

   task automatic do_reset();
      @(negedge clk); rest = 1'b1;
      @(negedge clk); rest = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] pick[8];
      int ev0, ack0;

      rest = 1'b1;
      m_events = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst.nextdata_n", 32'(rx_if.nextdata_n), 32'(1));
      chk("rst.key_event",  32'(key_event), 32'(0));
      check_all("rst");
      rest = 1'b0;

      // Make then break
      send(8'h1C);
      chk("make.key_code", 32'(key_code), 32'h1C);
      chk("make.cnt",      32'(press_cnt), 32'h01);
      send(8'hF0); send(8'h1C);
      chk("break.pressed", 32'(pressed), 32'(0));

      // Typematic repeat
      do_reset();
      ev0 = ev_seen;
      send(8'h1C); send(8'h1C); send(8'h1C);
      repeat (2) @(negedge clk);
      chk("typematic.events", 32'(ev_seen - ev0), 32'(1));
      chk("typematic.cnt",    32'(press_cnt), 32'h01);

      // Extended key, non-extended break ignored
      do_reset();
      send(8'hE0); send(8'h75);
      chk("ext.key_ext", 32'(key_ext), 32'(1));
      send(8'hF0); send(8'h75);
      chk("ext.plain_break_ignored", 32'(pressed), 32'(1));
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("ext.released", 32'(pressed), 32'(0));

      // Rollover
      do_reset();
      send(8'h1C); send(8'h32);
      chk("roll.cnt", 32'(press_cnt), 32'h02);
      send(8'hF0); send(8'h1C);
      chk("roll.held", 32'(pressed), 32'(1));
      send(8'hF0); send(8'h32);
      chk("roll.released", 32'(pressed), 32'(0));

      // Error byte aborts a prefix
      send(8'hE0); send(8'h00); send(8'h75);
      chk("err.not_ext", 32'(key_ext), 32'(0));

      // BCD carry and wrap
      do_reset();
      for (int i = 0; i < 100; i++) begin
         send((i % 2 == 0) ? 8'h1C : 8'h32);
         if (i == 8)  chk("bcd.09", 32'(press_cnt), 32'h09);
         if (i == 9)  chk("bcd.10", 32'(press_cnt), 32'h10);
         if (i == 98) chk("bcd.99", 32'(press_cnt), 32'h99);
      end
      chk("bcd.wrap", 32'(press_cnt), 32'h00);

      // Back-to-back FIFO contents
      ack0 = ack_cnt;
      q = '{8'h2A, 8'h2B, 8'h2C};
      burst(q);
      chk("hs.pops", 32'(ack_cnt - ack0), 32'(3));
      chk("hs.spacing", 32'(ack_b2b), 32'(0));

      // Reset while in ACK
      send(8'h1C);
      @(posedge clk); #1;
      fifo.push_back(8'h4D);
      @(negedge clk);
      @(negedge clk);
      chk("rstack.in_ack", 32'(rx_if.nextdata_n), 32'(0));
      rest = 1'b1;
      @(negedge clk);
      rest = 1'b0;
      model_reset();
      chk("rstack.nextdata_n", 32'(rx_if.nextdata_n), 32'(1));
      chk("rstack.key_event",  32'(key_event), 32'(0));
      check_all("rstack");
      repeat (2) @(negedge clk);
      ev_seen = m_events;

      // Randomized singles and bursts
      pick = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h00, 8'hFF, 8'h1C};
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 7) == 0) send(8'($urandom));
         else send(pick[$urandom_range(0, 7)]);
      end
      for (int i = 0; i < 25; i++) begin
         q.delete();
         for (int k = 0; k < int'($urandom_range(1, 8)); k++)
            q.push_back(pick[$urandom_range(0, 7)]);
         burst(q);
      end
      chk("hs.spacing_final", 32'(ack_b2b), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
